// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// It uses a radix-2 shift-add multiplier and a restoring divider, and
// takes DATA_WIDTH iterations plus one finalize cycle per operation.
// Divide-by-zero and signed overflow complete in one cycle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for a request
// CALC  | iterating; cnt counts completed iterations, finalize at cnt==W
// DONE  | result held with out_valid until out_ready
module muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            op,
    input  logic [DATA_WIDTH-1:0] in1,
    input  logic [DATA_WIDTH-1:0] in2,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(W);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2*W-1:0]   acc;      // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [W-1:0]     opnd;     // multiplicand or divisor magnitude
    logic             neg;      // negate the final result

    logic             is_div, is_rem, sgn1, sgn2, div_zero, div_ovf, special, neg_acc;
    logic [W-1:0]     mag1, mag2, special_res;

    logic [W:0]       mul_sum;
    logic [W:0]       rem_sh;
    logic [W+1:0]     div_diff;
    logic [2*W-1:0]   acc_step, prod;
    logic [W-1:0]     final_res;

    // Decode the request being presented: operand magnitudes, result sign, special cases.
    always_comb begin
        is_div = op[2];
        is_rem = op[2] & op[1];
        if (is_div) begin
            sgn1 = ~op[0] & in1[W-1];
            sgn2 = ~op[0] & in2[W-1];
        end else begin
            sgn1 = (op == 3'b001 || op == 3'b010) & in1[W-1];
            sgn2 = (op == 3'b001) & in2[W-1];
        end
        mag1     = sgn1 ? -in1 : in1;
        mag2     = sgn2 ? -in2 : in2;
        div_zero = is_div && (in2 == '0);
        div_ovf  = is_div && !op[0] && (in1 == {1'b1, {(W-1){1'b0}}}) && (in2 == '1);
        special  = div_zero | div_ovf;
        if (div_zero) special_res = op[1] ? in1 : '1;
        else          special_res = op[1] ? '0  : in1;
        neg_acc  = is_rem ? sgn1 : (sgn1 ^ sgn2);
    end

    // One multiply or divide iteration, plus the sign-corrected final result.
    always_comb begin
        mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
        rem_sh   = acc[2*W-1:W-1];
        div_diff = {1'b0, rem_sh} - {2'b00, opnd};
        if (!op_q[2])
            acc_step = {mul_sum, acc[W-1:1]};
        else if (!div_diff[W+1])
            acc_step = {div_diff[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_step = {rem_sh[W-1:0], acc[W-2:0], 1'b0};

        prod = neg ? -acc : acc;
        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
        else if (op_q[1])
            final_res = neg ? -acc[2*W-1:W] : acc[2*W-1:W];
        else
            final_res = neg ? -acc[W-1:0] : acc[W-1:0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // Datapath: load on accept, iterate in CALC, register the result when finishing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q   <= '0;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            neg    <= 1'b0;
            result <= '0;
            zero   <= 1'b1;
        end else if (state == IDLE && in_valid && !flush) begin
            op_q <= op;
            cnt  <= '0;
            acc  <= {{W{1'b0}}, mag1};
            opnd <= mag2;
            neg  <= neg_acc;
            if (special) begin
                result <= special_res;
                zero   <= (special_res == '0);
            end
        end else if (state == CALC && !flush) begin
            if (cnt == LAST) begin
                result <= final_res;
                zero   <= (final_res == '0);
            end else begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at DATA_WIDTH=32.
// It uses directed vectors and a randomized run against a 64-bit arithmetic model.
module tb_muldiv_unit;
    logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] in1 = '0, in2 = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;
    int          n_cmp = 0, n_err = 0;

    muldiv_unit #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .in1(in1), .in2(in2), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero), .busy(busy)
    );

    // 10 time-unit clock period.
    always #5 clk = ~clk;

    // Reference model: RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        logic [63:0] p;
        logic [63:0] q;
        bit ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = 64'(sa / sb); return q[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = 64'(ua / ub); return q[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = 64'(sa % sb); return q[31:0];
            end
            default: begin
                if (b == 0) return a;
                q = 64'(ua % ub); return q[31:0];
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    // Present a request for one cycle. Operands are scrambled afterwards,
    // because the unit must sample them only at the accept edge.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; in1 = a; in2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op = 3'($urandom); in1 = $urandom; in2 = $urandom;
    endtask

    // Cycles from the accept edge until out_valid. Returns -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = i; break; end
        end
    endtask

    task automatic take();
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1001 || result !== 32'h0) begin
            n_err++;
            $display("FAIL reset: rdy/vld/busy/zero=%b result=%h, required 1001 / 00000000",
                     {in_ready, out_valid, busy, zero}, result);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  t_op[12];
        logic [31:0] t_a[12], t_b[12], t_r[12];
        int          t_lat[12];
        int          lat;
        t_op  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
        t_a   = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                  32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        t_b   = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                  32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        t_r   = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                  32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        t_lat = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 12; i++) begin
            start_op(t_op[i], t_a[i], t_b[i]);
            wait_valid(lat);
            n_cmp++;
            if (lat != t_lat[i] || result !== t_r[i] || zero !== (t_r[i] == 0)) begin
                n_err++;
                $display("FAIL directed[%0d] op=%0d: lat=%0d result=%h zero=%b, required lat=%0d result=%h zero=%b",
                         i, t_op[i], lat, result, zero, t_lat[i], t_r[i], t_r[i] == 0);
            end
            take();
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b, exp;
        int          lat;
        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom); a = $urandom; b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
                3: b = $urandom_range(0, 3) << $urandom_range(0, 31);
                default: ;
            endcase
            exp = model(o, a, b);
            start_op(o, a, b);
            wait_valid(lat);
            n_cmp++;
            if (lat != model_lat(o, a, b) || result !== exp || zero !== (exp == 0)) begin
                n_err++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: lat=%0d result=%h zero=%b, required lat=%0d result=%h",
                         i, o, a, b, lat, result, zero, model_lat(o, a, b), exp);
            end
            take();
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [31:0] exp = model(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
        start_op(3'd0, 32'h1234_5678, 32'h9ABC_DEF1);
        n_cmp++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_accept: in_ready=%b busy=%b, required 0/1", in_ready, busy);
        end
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp) begin
                n_err++;
                $display("FAIL hold[%0d]: out_valid=%b in_ready=%b result=%h, required 1/0/%h",
                         i, out_valid, in_ready, result, exp);
            end
        end
        take();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL handoff: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
        end
        exp = model(3'd5, 32'd1000, 32'd9);
        start_op(3'd5, 32'd1000, 32'd9);
        wait_valid(lat);
        n_cmp++;
        if (lat != 33 || result !== exp) begin
            n_err++;
            $display("FAIL next_request: lat=%0d result=%h, required 33/%h", lat, result, exp);
        end
        take();
    endtask

    task automatic test_flush();
        int          seen = 0;
        int          lat;
        logic [31:0] exp;
        start_op(3'd4, 32'h7654_3210, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL flush_calc: busy=%b in_ready=%b out_valid=%b, required 0/1/0", busy, in_ready, out_valid);
        end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL flush_no_result: out_valid seen %0d cycles, required 0", seen);
        end
        // A request presented together with flush must be dropped.
        @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'd0; in1 = 32'd3; in2 = 32'd3;
        @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_blocks_accept: busy=%b, required 0", busy);
        end
        // Flushing a held result drops out_valid.
        start_op(3'd5, 32'd9, 32'd0);
        wait_valid(lat);
        @(negedge clk); flush = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0/1", out_valid, in_ready);
        end
        exp = model(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        start_op(3'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        wait_valid(lat);
        n_cmp++;
        if (lat != 33 || result !== exp) begin
            n_err++;
            $display("FAIL after_flush: lat=%0d result=%h, required 33/%h", lat, result, exp);
        end
        take();
    endtask

    task automatic test_reset_mid_calc();
        int          lat;
        logic [31:0] exp;
        start_op(3'd0, 32'hFFFF_0001, 32'h0000_0003);
        repeat (5) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({in_ready, out_valid, busy, zero} !== 4'b1001 || result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_calc: rdy/vld/busy/zero=%b result=%h, required 1001 / 00000000",
                     {in_ready, out_valid, busy, zero}, result);
        end
        @(negedge clk); rst_n = 1'b1;
        exp = model(3'd6, 32'hFFFF_FF85, 32'd10);
        start_op(3'd6, 32'hFFFF_FF85, 32'd10);
        wait_valid(lat);
        n_cmp++;
        if (lat != 33 || result !== exp) begin
            n_err++;
            $display("FAIL after_reset: lat=%0d result=%h, required 33/%h", lat, result, exp);
        end
        take();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid_calc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
